// File: rtl/trng_bit_source.sv
// -----------------------------------------------------------------------------
// trng_bit_source
//
// Producer end of the EN / RANDOM / BIT_READY / ACK handshake used by the
// display-side bit collector. One instance drives one random bit lane.
//
// The raw oscillator bit is synchronised, then sampled once every SAMPLE_DIV
// clocks while a pair is being collected. Samples are taken in pairs
// (von Neumann extractor):
//   - (0,1) yields bit 0.
//   - (1,0) yields bit 1.
//   - Equal pairs are thrown away.
//
// Each extracted bit is presented with a level-held ready/ack handshake.
// A repetition-count health test watches every raw sample. Once it trips,
// it latches HEALTH_FAIL and parks the block in IDLE until reset.
//
// Parameters
//   SAMPLE_DIV   clocks between entropy samples (>= 2)
//   SYNC_STAGES  synchroniser depth on ENTROPY (>= 2)
//   REP_LIMIT    consecutive identical raw samples that trip HEALTH_FAIL (>= 2)
//
// Ports
//   CLK          in   system clock, the only clock
//   RST          in   synchronous active-high reset, highest priority
//   EN           in   collector request (level); low returns to IDLE
//   ACK          in   collector acknowledge, only honoured in READY
//   ENTROPY      in   raw asynchronous oscillator bit
//   RANDOM       out  extracted bit, valid and stable while BIT_READY = 1
//   BIT_READY    out  RANDOM valid, held until ACK
//   HEALTH_FAIL  out  sticky repetition-count failure flag
// -----------------------------------------------------------------------------
module trng_bit_source #(
  parameter int SAMPLE_DIV  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int REP_LIMIT   = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic ACK,
  input  logic ENTROPY,
  output logic RANDOM,
  output logic BIT_READY,
  output logic HEALTH_FAIL
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic                   bit_a_q,  bit_a_d;
  logic                   prev_q,   prev_d;
  logic [REP_W-1:0]       rep_q,    rep_d;
  logic                   random_q, random_d;
  logic                   ready_q,  ready_d;
  logic                   hfail_q,  hfail_d;

  // Combinational helpers
  logic             ent_s;
  logic             sampling_s;
  logic             strobe_s;
  logic [REP_W-1:0] rep_step_s;
  logic             rep_trip_s;

  assign ent_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  // Shift the asynchronous oscillator bit through the synchroniser chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ENTROPY};
    end
  end

  // ---------------------------------------------------------------------------
  // Sample strobe and repetition-count step
  // ---------------------------------------------------------------------------
  // The counter only runs while a pair is being collected, so the strobe
  // can only fire in FIRST or SECOND.
  //
  // A repetition count of zero means "no previous sample since IDLE".
  // In that case the first strobe always restarts the run at one.
  always_comb begin
    sampling_s = (state_q == ST_FIRST) || (state_q == ST_SECOND);
    strobe_s   = sampling_s && (cnt_q == CNT_LAST);

    if ((rep_q == REP_ZERO) || (ent_s != prev_q)) begin
      rep_step_s = REP_ONE;
    end else if (rep_q == REP_MAX) begin
      rep_step_s = rep_q;
    end else begin
      rep_step_s = rep_q + REP_ONE;
    end

    rep_trip_s = strobe_s && (rep_step_s == REP_MAX);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and output values
  // ---------------------------------------------------------------------------
  // Next-state logic for the pair extractor, handshake and health test.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_a_d  = bit_a_q;
    prev_d   = prev_q;
    rep_d    = rep_q;
    random_d = random_q;
    ready_d  = ready_q;
    hfail_d  = hfail_q;

    if ((state_q != ST_IDLE) && !EN) begin
      // Dropping EN abandons any pair in progress or pending bit.
      // It wins over a coincident ACK. RANDOM keeps its last value.
      state_d = ST_IDLE;
      ready_d = 1'b0;
      cnt_d   = CNT_ZERO;
      rep_d   = REP_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (EN && !hfail_q) begin
            state_d = ST_FIRST;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FIRST, ST_SECOND: begin
          if (strobe_s) begin
            cnt_d  = CNT_ZERO;
            prev_d = ent_s;
            rep_d  = rep_step_s;

            if (state_q == ST_FIRST) begin
              bit_a_d = ent_s;
              state_d = ST_SECOND;
            end else if (ent_s != bit_a_q) begin
              state_d  = ST_READY;
              random_d = bit_a_q;
              ready_d  = 1'b1;
            end else begin
              // Equal pair carries bias only: discard and start a new pair.
              state_d = ST_FIRST;
            end

            // A tripped health test overrides any pair that completes
            // on the same edge.
            if (rep_trip_s) begin
              hfail_d  = 1'b1;
              state_d  = ST_IDLE;
              ready_d  = 1'b0;
              random_d = random_q;
            end else begin
              hfail_d = hfail_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_READY: begin
          if (ACK) begin
            state_d = ST_FIRST;
            ready_d = 1'b0;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_READY;
          end
        end

        default: begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          cnt_d   = CNT_ZERO;
          rep_d   = REP_ZERO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // State, datapath and output registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      bit_a_q  <= 1'b0;
      prev_q   <= 1'b0;
      rep_q    <= REP_ZERO;
      random_q <= 1'b0;
      ready_q  <= 1'b0;
      hfail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_a_q  <= bit_a_d;
      prev_q   <= prev_d;
      rep_q    <= rep_d;
      random_q <= random_d;
      ready_q  <= ready_d;
      hfail_q  <= hfail_d;
    end
  end

  assign RANDOM      = random_q;
  assign BIT_READY   = ready_q;
  assign HEALTH_FAIL = hfail_q;

endmodule

// File: tb/tb_trng_bit_source.sv
// -----------------------------------------------------------------------------
// tb_trng_bit_source
//
// Scoreboarded bench for trng_bit_source (SAMPLE_DIV=4, SYNC_STAGES=2,
// REP_LIMIT=8).
//
// ENTROPY is driven on the falling edge. Its value reaches the sample point
// two clocks later.
//
// Each pair that should produce a bit pushes the expected bit when its
// stimulus starts. The monitor pops and compares on every rising BIT_READY.
// -----------------------------------------------------------------------------
module tb_trng_bit_source;

  localparam int SD = 4;
  localparam int SS = 2;
  localparam int RL = 8;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic ACK;
  logic ENTROPY;
  logic RANDOM;
  logic BIT_READY;
  logic HEALTH_FAIL;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic rdy_prev = 1'b0;

  trng_bit_source #(
    .SAMPLE_DIV (SD),
    .SYNC_STAGES(SS),
    .REP_LIMIT  (RL)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .ACK        (ACK),
    .ENTROPY    (ENTROPY),
    .RANDOM     (RANDOM),
    .BIT_READY  (BIT_READY),
    .HEALTH_FAIL(HEALTH_FAIL)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Scoreboard: every rising BIT_READY must match the oldest queued bit.
  always @(negedge CLK) begin
    if (BIT_READY && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_ready", BIT_READY, 1'b0);
      end else begin
        check_eq("random", RANDOM, exp_q.pop_front());
      end
    end
    rdy_prev = BIT_READY;
  end

  // Call on the falling edge just before the edge that enters FIRST.
  //
  // The first sample of the pair is a and the second is b. ACK is held for
  // ack_cyc edges, starting at the entry edge.
  //
  // When a and b differ, the task returns one negedge after BIT_READY should
  // rise. When they are equal, it returns on the negedge just before the
  // next pair starts.
  task automatic pair(input logic a, input logic b, input int ack_cyc,
                      input string tag);
    ENTROPY = a;
    ACK     = (ack_cyc > 0) ? 1'b1 : 1'b0;
    if (a != b) exp_q.push_back(a);
    for (int i = 1; i <= 2 * SD; i++) begin
      @(negedge CLK);
      if (i >= ack_cyc) ACK = 1'b0;
      if (i == SD) ENTROPY = b;
      if (i == 1) check_eq({tag, "_entry"}, BIT_READY, 1'b0);
      if (i == 2 * SD) check_eq({tag, "_early"}, BIT_READY, 1'b0);
    end
    if (a != b) begin
      @(negedge CLK);
      check_eq({tag, "_ready"}, BIT_READY, 1'b1);
    end
  endtask

  initial begin
    RST     = 1'b1;
    EN      = 1'b0;
    ACK     = 1'b0;
    ENTROPY = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_random", RANDOM, 1'b0);
    check_eq("rst_ready", BIT_READY, 1'b0);
    check_eq("rst_hfail", HEALTH_FAIL, 1'b0);
    RST = 1'b0;

    // Best-case latency: (1,0) gives bit 1 after 2*SD cycles.
    EN = 1'b1;
    pair(1'b1, 1'b0, 0, "t1");

    // Discarded (0,0) pair, then (0,1) gives bit 0 one pair later.
    pair(1'b0, 1'b0, 1, "t2a");
    pair(1'b0, 1'b1, 0, "t2b");

    // Presented bit is held with no ACK while ENTROPY keeps moving.
    for (int i = 1; i <= 50; i++) begin
      ENTROPY = ~ENTROPY;
      @(negedge CLK);
      if (i % 10 == 0) begin
        check_eq("hold_ready", BIT_READY, 1'b1);
        check_eq("hold_random", RANDOM, 1'b0);
      end
    end

    // One-cycle ACK, then an ACK held over several cycles.
    pair(1'b1, 1'b0, 1, "t3");
    pair(1'b0, 1'b1, 3, "t3hold");

    // EN low together with ACK: return to IDLE and keep RANDOM.
    // Raising EN again at once must restart from IDLE with full latency.
    EN  = 1'b0;
    ACK = 1'b1;
    @(negedge CLK);
    check_eq("enlow_ready", BIT_READY, 1'b0);
    check_eq("enlow_random", RANDOM, 1'b0);
    ACK = 1'b0;
    EN  = 1'b1;
    pair(1'b1, 1'b0, 0, "t5");

    // Reset pulsed while in SECOND; EN stays high, so collection restarts.
    ACK     = 1'b1;
    ENTROPY = 1'b0;
    @(negedge CLK);
    ACK = 1'b0;
    repeat (SD) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("midrst_random", RANDOM, 1'b0);
    check_eq("midrst_ready", BIT_READY, 1'b0);
    check_eq("midrst_hfail", HEALTH_FAIL, 1'b0);
    RST = 1'b0;
    pair(1'b0, 1'b1, 0, "t6");

    // Health test: a stuck-at-1 source trips on the REP_LIMIT-th strobe.
    EN      = 1'b0;
    ENTROPY = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("t4_idle_ready", BIT_READY, 1'b0);
    EN = 1'b1;
    repeat (RL * SD) @(negedge CLK);
    check_eq("hfail_before", HEALTH_FAIL, 1'b0);
    @(negedge CLK);
    check_eq("hfail_trip", HEALTH_FAIL, 1'b1);
    check_eq("hfail_ready", BIT_READY, 1'b0);
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    EN = 1'b1;
    repeat (20) @(negedge CLK);
    check_eq("hfail_sticky", HEALTH_FAIL, 1'b1);
    check_eq("hfail_idle", BIT_READY, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("hfail_rst", HEALTH_FAIL, 1'b0);
    RST = 1'b0;
    EN  = 1'b0;
    repeat (2) @(negedge CLK);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expected bits never presented", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
